cmd_proc_param: RTL

- Parametrised command processor for the Knight's Tour robot, second generation.
- Decodes 16-bit BLE/tour commands and sequences gyro calibration, heading-align/ramp-up/ramp-down moves of 1..(2^SQ_W-1) squares, tour kick-off, and a new STOP/abort command.
- Drives error and frwrd to the PID/motor path, moving to the gyro integrator, and send_resp to the UART wrapper.

---
 rtl/cmd_proc_if.sv | 11 +
 rtl/cmd_proc_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cmd_proc_if.sv
// Command handshake between the BLE/tour command source and cmd_proc_param.
// The master drives the command word; the slave consumes it and signals completion.
interface cmd_proc_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;

    modport master (output cmd, output cmd_rdy, input clr_cmd_rdy, input send_resp);
    modport slave  (input cmd, input cmd_rdy, output clr_cmd_rdy, output send_resp);
endinterface

// File: rtl/cmd_proc_param.sv
// Knight's Tour command processor: calibrate, align/ramp/slow moves, tour kick-off, stop.
// Optional macro MOVE_TIMEOUT_EN adds a per-line watchdog (LINE_TO) and a move_err pulse.
module cmd_proc_param #(
    parameter int          FRWRD_W   = 10,
    parameter int          SQ_W      = 2,
    parameter logic [9:0]  INC       = 10'h004,
    parameter logic [9:0]  DEC       = 10'h008,
    parameter logic [11:0] ALIGN_THR = 12'h030,
    parameter logic [11:0] NUDGE     = 12'h05F
`ifdef MOVE_TIMEOUT_EN
    ,
    parameter logic [23:0] LINE_TO   = 24'd5_000_000
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    cmd_proc_if.slave          bus,
    output logic               strt_cal,
    input  logic               cal_done,
    input  logic [11:0]        heading,
    input  logic               heading_rdy,
    input  logic               lftIR,
    input  logic               rghtIR,
    input  logic               cntrIR,
    output logic [11:0]        error,
    output logic [FRWRD_W-1:0] frwrd,
    output logic               moving,
    output logic               tour_go,
    output logic               fanfare_go
`ifdef MOVE_TIMEOUT_EN
    ,
    output logic               move_err
`endif
);

    typedef enum logic [2:0] {IDLE, CAL, ALIGN, RAMP, SLOW} state_t;

    localparam logic [3:0] OP_CAL      = 4'h0;
    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;
    localparam logic [3:0] OP_TOUR     = 4'h4;
    localparam logic [3:0] OP_STOP     = 4'h5;

    localparam logic [FRWRD_W-1:0] INC_W  = FRWRD_W'(INC);
    localparam logic [FRWRD_W-1:0] DEC_W  = FRWRD_W'(DEC);
    localparam logic signed [11:0] THR_S  = ALIGN_THR;
    localparam logic [SQ_W:0]      ONE_CNT = (SQ_W+1)'(1);

    state_t             state_reg;
    logic [FRWRD_W-1:0] frwrd_reg;
    logic [11:0]        desired_reg;
    logic [SQ_W:0]      target_reg;
    logic [SQ_W:0]      count_reg;
    logic               fanfare_reg;
    logic               cntr_reg;

    logic [3:0]         op;
    logic               is_stop;
    logic               line_rise;
    logic               hit;
    logic               aligned;
    logic               expired;
    logic [11:0]        nudge;
    logic [FRWRD_W:0]   inc_sum;
    logic [FRWRD_W-1:0] inc_next;
    logic [FRWRD_W-1:0] dec_next;

    // Only the opcode, heading and square-count fields carry meaning.
    wire unused_cmd_bits = &{1'b0, bus.cmd};

    assign op        = bus.cmd[15:12];
    assign is_stop   = bus.cmd_rdy && (op == OP_STOP);
    assign line_rise = cntrIR && !cntr_reg;
    assign hit       = (count_reg == target_reg);

    always_comb begin
        nudge = 12'h000;
        if (state_reg == RAMP || state_reg == SLOW) begin
            if (lftIR)
                nudge = NUDGE;
            else if (rghtIR)
                nudge = 12'h000 - NUDGE;
        end
    end

    assign error   = heading - desired_reg + nudge;
    assign aligned = ($signed(error) > -THR_S) && ($signed(error) < THR_S);

    // Ramp holds once the top two bits are set; carry-out saturates for oversize INC.
    assign inc_sum  = {1'b0, frwrd_reg} + {1'b0, INC_W};
    assign inc_next = (frwrd_reg[FRWRD_W-1:FRWRD_W-2] == 2'b11) ? frwrd_reg :
                      inc_sum[FRWRD_W] ? '1 : inc_sum[FRWRD_W-1:0];
    assign dec_next = (frwrd_reg < DEC_W) ? '0 : frwrd_reg - DEC_W;

    assign frwrd           = frwrd_reg;
    assign moving          = (state_reg == ALIGN) || (state_reg == RAMP) || (state_reg == SLOW);
    assign bus.clr_cmd_rdy = ((state_reg == IDLE) && bus.cmd_rdy) || ((state_reg == RAMP) && is_stop);
    assign strt_cal        = (state_reg == IDLE) && bus.cmd_rdy && (op == OP_CAL);
    assign tour_go         = (state_reg == IDLE) && bus.cmd_rdy && (op == OP_TOUR);
    assign fanfare_go      = (state_reg == RAMP) && hit && fanfare_reg;
    assign bus.send_resp   = ((state_reg == IDLE) && is_stop) ||
                             ((state_reg == CAL) && cal_done) ||
                             ((state_reg == SLOW) && (frwrd_reg == '0));

`ifdef MOVE_TIMEOUT_EN
    logic [23:0] tmo_cnt_reg;
    logic        tmo_flag_reg;
    logic        move_accept;

    assign move_accept = (state_reg == IDLE) && bus.cmd_rdy && (op == OP_MOVE || op == OP_MOVE_FAN);
    assign expired     = (state_reg == RAMP) && !hit && (tmo_cnt_reg >= LINE_TO);
    assign move_err    = (state_reg == SLOW) && (frwrd_reg == '0) && tmo_flag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg  <= 24'd0;
            tmo_flag_reg <= 1'b0;
        end else begin
            if (move_accept || line_rise)
                tmo_cnt_reg <= 24'd0;
            else if (state_reg == RAMP && tmo_cnt_reg != 24'hFF_FFFF)
                tmo_cnt_reg <= tmo_cnt_reg + 24'd1;
            if (move_accept)
                tmo_flag_reg <= 1'b0;
            else if (expired)
                tmo_flag_reg <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            frwrd_reg   <= '0;
            desired_reg <= 12'h000;
            target_reg  <= '0;
            count_reg   <= '0;
            fanfare_reg <= 1'b0;
            cntr_reg    <= 1'b0;
        end else begin
            cntr_reg <= cntrIR;
            unique case (state_reg)
                IDLE: begin
                    if (bus.cmd_rdy) begin
                        case (op)
                            OP_CAL: state_reg <= CAL;
                            OP_MOVE, OP_MOVE_FAN: begin
                                desired_reg <= (bus.cmd[11:4] == 8'h00) ? 12'h000 : {bus.cmd[11:4], 4'hF};
                                target_reg  <= {bus.cmd[SQ_W-1:0], 1'b0};
                                fanfare_reg <= bus.cmd[12];
                                count_reg   <= '0;
                                state_reg   <= ALIGN;
                            end
                            default: ;
                        endcase
                    end
                end
                CAL: begin
                    if (cal_done)
                        state_reg <= IDLE;
                end
                ALIGN: begin
                    frwrd_reg <= '0;
                    if (aligned)
                        state_reg <= RAMP;
                end
                RAMP: begin
                    if (heading_rdy)
                        frwrd_reg <= inc_next;
                    if (line_rise)
                        count_reg <= count_reg + ONE_CNT;
                    if (hit || expired || is_stop)
                        state_reg <= SLOW;
                end
                SLOW: begin
                    if (frwrd_reg == '0)
                        state_reg <= IDLE;
                    else if (heading_rdy)
                        frwrd_reg <= dec_next;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
